// File: rtl/tlk_link_err_monitor_if.sv
// Receive-stream and verdict bundle between a TLK2711 channel and its link error monitor.
// The monitor takes the slave side; the stimulus/consumer side takes master.
interface tlk_link_err_monitor_if #(
    parameter int CNT_W = 16
);
    logic             enable;
    logic [15:0]      rx_data;
    logic             rx_k_lsb;
    logic             rx_k_msb;
    logic             err_in;
    logic             send_err;
    logic             link_locked;
    logic [CNT_W-1:0] err_count;

    modport master (
        output enable, rx_data, rx_k_lsb, rx_k_msb,
        input  err_in, send_err, link_locked, err_count
    );

    modport slave (
        input  enable, rx_data, rx_k_lsb, rx_k_msb,
        output err_in, send_err, link_locked, err_count
    );
endinterface

// File: rtl/tlk_link_err_monitor.sv
// Per-channel TLK2711 receive monitor: idle-based lock FSM plus windowed error counter
// whose verdict and strobe feed the downstream error-output latch.
module tlk_link_err_monitor #(
    parameter int WINDOW = 1024,
    parameter int THRESH = 4,
    parameter int LOCK_N = 16,
    parameter int LOSE_N = 4,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    tlk_link_err_monitor_if.slave mon
);

    localparam int WIN_W  = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam int GOOD_W = $clog2(LOCK_N + 1);
    localparam int BAD_W  = $clog2(LOSE_N + 1);

    localparam logic [15:0]       IDLE_CHAR = 16'hC5BC;
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [GOOD_W-1:0] LOCK_TGT  = GOOD_W'(LOCK_N);
    localparam logic [BAD_W-1:0]  LOSE_TGT  = BAD_W'(LOSE_N);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_LOS    = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input logic inc);
        if (inc && (cnt != CNT_MAX)) begin
            return cnt + CNT_W'(1);
        end else begin
            return cnt;
        end
    endfunction

    logic              err_word_s;
    logic              idle_word_s;
    logic              evt_s;
    logic              win_last_s;
    logic              err_over_s;
    logic [CNT_W-1:0]  err_total_s;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [GOOD_W-1:0] good_cnt_r;
    logic [GOOD_W-1:0] good_cnt_nxt_s;
    logic [GOOD_W-1:0] good_inc_s;
    logic [BAD_W-1:0]  bad_cnt_r;
    logic [BAD_W-1:0]  bad_cnt_nxt_s;
    logic [BAD_W-1:0]  bad_inc_s;
    logic              link_locked_r;

    logic [WIN_W-1:0]  win_cnt_r;
    logic [CNT_W-1:0]  err_cnt_r;
    logic [CNT_W-1:0]  err_count_r;
    logic              err_in_r;
    logic              send_err_r;

    // Word classification; both K flags set is the TLK error-propagation code.
    always_comb begin
        err_word_s  = mon.rx_k_msb & mon.rx_k_lsb;
        idle_word_s = mon.rx_k_lsb & ~mon.rx_k_msb & (mon.rx_data == IDLE_CHAR);
    end

    // Lock FSM state and run-length counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= ST_LOS;
            good_cnt_r    <= {GOOD_W{1'b0}};
            bad_cnt_r     <= {BAD_W{1'b0}};
            link_locked_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            good_cnt_r    <= good_cnt_nxt_s;
            bad_cnt_r     <= bad_cnt_nxt_s;
            link_locked_r <= (state_nxt_s == ST_LOCKED);
        end
    end

    // Lock FSM next-state: idles build lock, error words tear it down.
    always_comb begin
        state_nxt_s    = state_r;
        good_cnt_nxt_s = good_cnt_r;
        bad_cnt_nxt_s  = bad_cnt_r;
        good_inc_s     = good_cnt_r + GOOD_W'(1);
        bad_inc_s      = bad_cnt_r + BAD_W'(1);
        case (state_r)
            ST_LOS: begin
                if (idle_word_s) begin
                    if (LOCK_N == 1) begin
                        state_nxt_s    = ST_LOCKED;
                        good_cnt_nxt_s = {GOOD_W{1'b0}};
                        bad_cnt_nxt_s  = {BAD_W{1'b0}};
                    end else begin
                        state_nxt_s    = ST_HUNT;
                        good_cnt_nxt_s = GOOD_W'(1);
                    end
                end else begin
                    good_cnt_nxt_s = {GOOD_W{1'b0}};
                end
            end
            ST_HUNT: begin
                if (err_word_s) begin
                    state_nxt_s    = ST_LOS;
                    good_cnt_nxt_s = {GOOD_W{1'b0}};
                end else if (idle_word_s) begin
                    if (good_inc_s == LOCK_TGT) begin
                        state_nxt_s    = ST_LOCKED;
                        good_cnt_nxt_s = {GOOD_W{1'b0}};
                        bad_cnt_nxt_s  = {BAD_W{1'b0}};
                    end else begin
                        good_cnt_nxt_s = good_inc_s;
                    end
                end else begin
                    good_cnt_nxt_s = good_cnt_r;
                end
            end
            ST_LOCKED: begin
                if (err_word_s) begin
                    if (bad_inc_s == LOSE_TGT) begin
                        state_nxt_s    = ST_LOS;
                        good_cnt_nxt_s = {GOOD_W{1'b0}};
                        bad_cnt_nxt_s  = {BAD_W{1'b0}};
                    end else begin
                        bad_cnt_nxt_s = bad_inc_s;
                    end
                end else begin
                    bad_cnt_nxt_s = {BAD_W{1'b0}};
                end
            end
            default: begin
                state_nxt_s    = ST_LOS;
                good_cnt_nxt_s = {GOOD_W{1'b0}};
                bad_cnt_nxt_s  = {BAD_W{1'b0}};
            end
        endcase
    end

    // Per-cycle error event and running window total; unlocked cycles count as errors.
    always_comb begin
        evt_s       = err_word_s | (state_r != ST_LOCKED);
        err_total_s = sat_add(err_cnt_r, evt_s);
        win_last_s  = (win_cnt_r == WIN_LAST);
        err_over_s  = (32'(err_total_s) >= 32'(THRESH));
    end

    // Window counter; the closing cycle publishes the verdict and restarts with no gap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            win_cnt_r   <= {WIN_W{1'b0}};
            err_cnt_r   <= {CNT_W{1'b0}};
            err_count_r <= {CNT_W{1'b0}};
            err_in_r    <= 1'b0;
            send_err_r  <= 1'b0;
        end else if (!mon.enable) begin
            win_cnt_r  <= {WIN_W{1'b0}};
            err_cnt_r  <= {CNT_W{1'b0}};
            send_err_r <= 1'b0;
        end else if (win_last_s) begin
            err_count_r <= err_total_s;
            err_in_r    <= err_over_s;
            send_err_r  <= 1'b1;
            win_cnt_r   <= {WIN_W{1'b0}};
            err_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            win_cnt_r  <= win_cnt_r + WIN_W'(1);
            err_cnt_r  <= err_total_s;
            send_err_r <= 1'b0;
        end
    end

    assign mon.err_in      = err_in_r;
    assign mon.send_err    = send_err_r;
    assign mon.link_locked = link_locked_r;
    assign mon.err_count   = err_count_r;

endmodule

// File: tb/tb_tlk_link_err_monitor.sv
// Bench for tlk_link_err_monitor: two instances (8-bit/16-cycle and 4-bit/32-cycle windows)
// checked against a behavioural model whose window verdicts flow through a scoreboard queue.
module tb_tlk_link_err_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, en, km, kl;
    logic [15:0] d;

    tlk_link_err_monitor_if #(.CNT_W(8)) if_a();
    tlk_link_err_monitor_if #(.CNT_W(4)) if_b();

    assign if_a.enable   = en;
    assign if_a.rx_data  = d;
    assign if_a.rx_k_lsb = kl;
    assign if_a.rx_k_msb = km;
    assign if_b.enable   = en;
    assign if_b.rx_data  = d;
    assign if_b.rx_k_lsb = kl;
    assign if_b.rx_k_msb = km;

    tlk_link_err_monitor #(.WINDOW(16), .THRESH(2), .LOCK_N(4), .LOSE_N(2), .CNT_W(8)) dut_a (
        .clk(clk), .reset(rst_a), .mon(if_a.slave)
    );
    tlk_link_err_monitor #(.WINDOW(32), .THRESH(2), .LOCK_N(4), .LOSE_N(2), .CNT_W(4)) dut_b (
        .clk(clk), .reset(rst_b), .mon(if_b.slave)
    );

    typedef struct {
        int cnt;
        int inn;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int n_checks = 0;
    int n_errors = 0;

    // Model state per instance: 0=LOS, 1=HUNT, 2=LOCKED
    int m_state[2];
    int m_good[2];
    int m_bad[2];
    int m_win[2];
    int m_err[2];
    int m_cnt[2];
    int m_in[2];
    bit m_strobe[2];

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int p_win(input int id);
        return (id == 0) ? 16 : 32;
    endfunction

    function automatic int p_max(input int id);
        return (id == 0) ? 255 : 15;
    endfunction

    task automatic model_step(input int id, input bit rst);
        bit   errw, idlew, evt;
        int   tot;
        exp_t e;
        errw  = km && kl;
        idlew = kl && !km && (d == 16'hC5BC);
        if (!rst) begin
            m_state[id] = 0; m_good[id] = 0; m_bad[id] = 0;
            m_win[id] = 0; m_err[id] = 0; m_cnt[id] = 0; m_in[id] = 0;
            m_strobe[id] = 1'b0;
        end else begin
            evt = errw || (m_state[id] != 2);
            if (!en) begin
                m_win[id] = 0;
                m_err[id] = 0;
                m_strobe[id] = 1'b0;
            end else begin
                tot = m_err[id] + (evt ? 1 : 0);
                if (tot > p_max(id)) tot = p_max(id);
                if (m_win[id] == p_win(id) - 1) begin
                    m_cnt[id] = tot;
                    m_in[id]  = (tot >= 2) ? 1 : 0;
                    m_strobe[id] = 1'b1;
                    e.cnt = tot;
                    e.inn = m_in[id];
                    if (id == 0) q_a.push_back(e);
                    else         q_b.push_back(e);
                    m_win[id] = 0;
                    m_err[id] = 0;
                end else begin
                    m_win[id] = m_win[id] + 1;
                    m_err[id] = tot;
                    m_strobe[id] = 1'b0;
                end
            end
            case (m_state[id])
                0: if (idlew) begin m_state[id] = 1; m_good[id] = 1; end
                1: begin
                    if (errw) begin
                        m_state[id] = 0; m_good[id] = 0;
                    end else if (idlew) begin
                        m_good[id] = m_good[id] + 1;
                        if (m_good[id] == 4) begin m_state[id] = 2; m_bad[id] = 0; m_good[id] = 0; end
                    end
                end
                default: begin
                    if (errw) begin
                        m_bad[id] = m_bad[id] + 1;
                        if (m_bad[id] == 2) begin m_state[id] = 0; m_good[id] = 0; m_bad[id] = 0; end
                    end else begin
                        m_bad[id] = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic check_dut(input int id);
        logic [31:0] se, ei, ll, ec;
        exp_t e;
        if (id == 0) begin
            se = 32'(if_a.send_err); ei = 32'(if_a.err_in);
            ll = 32'(if_a.link_locked); ec = 32'(if_a.err_count);
        end else begin
            se = 32'(if_b.send_err); ei = 32'(if_b.err_in);
            ll = 32'(if_b.link_locked); ec = 32'(if_b.err_count);
        end
        chk_eq($sformatf("send_err[%0d]", id), se, 32'(m_strobe[id]));
        chk_eq($sformatf("link_locked[%0d]", id), ll, 32'((m_state[id] == 2) ? 1 : 0));
        chk_eq($sformatf("err_in_hold[%0d]", id), ei, m_in[id]);
        chk_eq($sformatf("err_count_hold[%0d]", id), ec, m_cnt[id]);
        if (se === 32'd1) begin
            if (id == 0) begin
                chk_eq("sb_pending_a", 32'(q_a.size()), 32'(q_a.size() > 0 ? q_a.size() : 1));
                if (q_a.size() > 0) begin
                    e = q_a.pop_front();
                    chk_eq("sb_cnt_a", ec, e.cnt);
                    chk_eq("sb_in_a", ei, e.inn);
                end
            end else begin
                chk_eq("sb_pending_b", 32'(q_b.size()), 32'(q_b.size() > 0 ? q_b.size() : 1));
                if (q_b.size() > 0) begin
                    e = q_b.pop_front();
                    chk_eq("sb_cnt_b", ec, e.cnt);
                    chk_eq("sb_in_b", ei, e.inn);
                end
            end
        end
    endtask

    task automatic cyc(input bit ra, input bit rb, input bit e, input bit m, input bit l, input logic [15:0] dd);
        rst_a = ra; rst_b = rb; en = e; km = m; kl = l; d = dd;
        @(posedge clk);
        model_step(0, ra);
        model_step(1, rb);
        @(negedge clk);
        check_dut(0);
        check_dut(1);
    endtask

    task automatic idle_a(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'hC5BC);
    endtask

    task automatic errw_a(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'($urandom));
    endtask

    task automatic good_a(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'($urandom));
    endtask

    task automatic good_b(input int n, input bit e);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, e, 1'b0, 1'b0, 16'($urandom));
    endtask

    initial begin
        // Reset with random traffic
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
        chk_eq("rst_send_err", 32'(if_a.send_err), 0);
        chk_eq("rst_err_in", 32'(if_a.err_in), 0);
        chk_eq("rst_link_locked", 32'(if_a.link_locked), 0);
        chk_eq("rst_err_count", 32'(if_a.err_count), 0);

        // Constant error words: first verdict after 16 enabled cycles
        errw_a(15);
        chk_eq("s1_no_early_strobe", 32'(if_a.send_err), 0);
        errw_a(1);
        chk_eq("s1_strobe", 32'(if_a.send_err), 1);
        chk_eq("s1_count", 32'(if_a.err_count), 16);
        chk_eq("s1_err_in", 32'(if_a.err_in), 1);

        // Lock acquisition from LOS
        idle_a(3);
        chk_eq("s2_not_locked_3", 32'(if_a.link_locked), 0);
        idle_a(1);
        chk_eq("s2_locked_4", 32'(if_a.link_locked), 1);
        idle_a(12);
        chk_eq("s2_hunt_window_cnt", 32'(if_a.err_count), 4);
        idle_a(16);
        chk_eq("s2_clean_strobe", 32'(if_a.send_err), 1);
        chk_eq("s2_clean_count", 32'(if_a.err_count), 0);
        chk_eq("s2_clean_err_in", 32'(if_a.err_in), 0);

        // Isolated errors keep lock; two consecutive drop it
        errw_a(1); idle_a(1); errw_a(1);
        chk_eq("s3_still_locked", 32'(if_a.link_locked), 1);
        idle_a(13);
        chk_eq("s3_strobe", 32'(if_a.send_err), 1);
        chk_eq("s3_count", 32'(if_a.err_count), 2);
        chk_eq("s3_err_in", 32'(if_a.err_in), 1);
        errw_a(1);
        chk_eq("s3_locked_after_1", 32'(if_a.link_locked), 1);
        errw_a(1);
        chk_eq("s3_unlocked_after_2", 32'(if_a.link_locked), 0);

        // Error during HUNT restarts the idle count
        idle_a(3);
        errw_a(1);
        chk_eq("s4_los", 32'(if_a.link_locked), 0);
        idle_a(3);
        chk_eq("s4_relock_3", 32'(if_a.link_locked), 0);
        idle_a(1);
        chk_eq("s4_relock_4", 32'(if_a.link_locked), 1);

        // Narrow counter saturation, enable drop, fresh window on re-enable
        good_b(32, 1'b1);
        chk_eq("s5_strobe", 32'(if_b.send_err), 1);
        chk_eq("s5_sat_count", 32'(if_b.err_count), 15);
        chk_eq("s5_err_in", 32'(if_b.err_in), 1);
        good_b(10, 1'b1);
        good_b(5, 1'b0);
        chk_eq("s5_dis_no_strobe", 32'(if_b.send_err), 0);
        chk_eq("s5_dis_err_in_hold", 32'(if_b.err_in), 1);
        good_b(31, 1'b1);
        chk_eq("s5_reen_no_early", 32'(if_b.send_err), 0);
        good_b(1, 1'b1);
        chk_eq("s5_reen_strobe", 32'(if_b.send_err), 1);
        good_b(31, 1'b1);
        good_b(1, 1'b0);
        chk_eq("s5_abandon_last", 32'(if_b.send_err), 0);
        good_b(3, 1'b0);

        // Reset mid-window clears verdict and restarts window from zero
        good_a(16);
        chk_eq("s6_pre_err_in", 32'(if_a.err_in), 1);
        good_a(5);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk_eq("s6_rst_err_in", 32'(if_a.err_in), 0);
        chk_eq("s6_rst_count", 32'(if_a.err_count), 0);
        chk_eq("s6_rst_locked", 32'(if_a.link_locked), 0);
        good_a(15);
        chk_eq("s6_no_early", 32'(if_a.send_err), 0);
        good_a(1);
        chk_eq("s6_strobe", 32'(if_a.send_err), 1);
        chk_eq("s6_count", 32'(if_a.err_count), 16);

        chk_eq("q_a_drained", 32'(q_a.size()), 0);
        chk_eq("q_b_drained", 32'(q_b.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
